wb_arbiter: RTL and testbench



---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_fifo.sv | 95 +++++++++
 rtl/wb_arbiter.sv | 94 +++++++++
 tb/tb_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back arbiter: default widths, the queue
// entry layout and the hard-wired zero register address.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                 live;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular queue of MDU results with per-entry kill and hazard-match logic.
// A killed or zero-address entry stays in place (live = 0) and is drained as a bubble.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [ADDR_W-1:0] kill_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              ready,
  output logic              head_valid,
  output logic              head_live,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              pend_a,
  output logic              pend_b
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              live;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               push_ok;
  logic               pop_ok;
  logic               push_live;

  // Ready depends on the registered count only; a same-cycle pop never frees a slot early.
  assign ready      = count < CNT_W'(DEPTH);
  assign head_valid = count != '0;
  assign head_live  = head_valid && q[rd_ptr].live;
  assign head_addr  = q[rd_ptr].addr;
  assign head_data  = q[rd_ptr].data;

  assign push_ok   = push && ready;
  assign pop_ok    = pop && head_valid;
  assign push_live = (push_addr != ADDR_W'(REG_ZERO)) &&
                     !(kill_en && (push_addr == kill_addr));

  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].live && (q[i].addr == rd_addr_a)) pend_a = 1'b1;
      if (q[i].live && (q[i].addr == rd_addr_b)) pend_b = 1'b1;
    end
    if (rd_addr_a == ADDR_W'(REG_ZERO)) pend_a = 1'b0;
    if (rd_addr_b == ADDR_W'(REG_ZERO)) pend_b = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && (q[i].addr == kill_addr)) q[i].live <= 1'b0;
      end
      if (pop_ok) begin
        q[rd_ptr].live <= 1'b0;
        rd_ptr         <= rd_ptr + PTR_W'(1);
      end
      if (push_ok) begin
        q[wr_ptr] <= '{live: push_live, addr: push_addr, data: push_data};
        wr_ptr    <= wr_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results win, queued MDU results fill idle slots.
// Optional same-cycle forwarding of the write value is enabled by WB_BYPASS_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              enable,
  output logic [ADDR_W-1:0] addr_w,
  output logic [DATA_W-1:0] data_w,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
`ifdef WB_BYPASS_EN
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b,
`endif
  output logic              pend_a,
  output logic              pend_b
);

  logic              alu_wr;
  logic              pop;
  logic              head_valid;
  logic              head_live;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  // MDU handshake: a result transfers on a rising edge where mdu_valid && mdu_ready;
  // the MDU holds addr/data stable while valid is high and ready is low.
  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (mdu_valid),
    .push_addr  (mdu_addr),
    .push_data  (mdu_data),
    .pop        (pop),
    .kill_en    (alu_wr),
    .kill_addr  (alu_addr),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .ready      (mdu_ready),
    .head_valid (head_valid),
    .head_live  (head_live),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .pend_a     (pend_a),
    .pend_b     (pend_b)
  );

  assign alu_wr = !reset && alu_valid && (alu_addr != ADDR_W'(REG_ZERO));

  // Dead heads cost no port slot, so they drain even while the ALU owns the port.
  assign pop = head_valid && (!head_live || !alu_wr);

  always_comb begin
    enable = 1'b0;
    addr_w = '0;
    data_w = '0;
    if (alu_wr) begin
      enable = 1'b1;
      addr_w = alu_addr;
      data_w = alu_data;
    end else if (head_live && !reset) begin
      enable = 1'b1;
      addr_w = head_addr;
      data_w = head_data;
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_hit_a  = enable && (addr_w == rd_addr_a) && (addr_w != ADDR_W'(REG_ZERO));
  assign fwd_hit_b  = enable && (addr_w == rd_addr_b) && (addr_w != ADDR_W'(REG_ZERO));
  assign fwd_data_a = data_w;
  assign fwd_data_b = data_w;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ALU priority, MDU queueing, kill rule, r0 and reset.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_wb_arbiter;

  logic        clock;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        enable;
  logic [4:0]  addr_w;
  logic [31:0] data_w;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        pend_a;
  logic        pend_b;
`ifdef WB_BYPASS_EN
  logic        fwd_hit_a;
  logic        fwd_hit_b;
  logic [31:0] fwd_data_a;
  logic [31:0] fwd_data_b;
`endif

  int checks;
  int errors;
  int zero_writes;
  logic [31:0] rf [32];

  wb_arbiter #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_addr  (mdu_addr),
    .mdu_data  (mdu_data),
    .enable    (enable),
    .addr_w    (addr_w),
    .data_w    (data_w),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
`ifdef WB_BYPASS_EN
    .fwd_hit_a (fwd_hit_a),
    .fwd_hit_b (fwd_hit_b),
    .fwd_data_a(fwd_data_a),
    .fwd_data_b(fwd_data_b),
`endif
    .pend_a    (pend_a),
    .pend_b    (pend_b)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register-array model and r0-write monitor
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (enable) begin
      rf[addr_w] <= data_w;
    end
    if (enable && addr_w == 5'd0) zero_writes <= zero_writes + 1;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
    rd_addr_a = '0;   rd_addr_b = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    #12;
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b want 1", mdu_ready); end
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL rst_enable got %0b want 0", enable); end
    checks++; if (addr_w !== 5'd0 || data_w !== 32'd0) begin errors++; $display("FAIL rst_wport got %0d/%h want 0/0", addr_w, data_w); end
    checks++; if (pend_a !== 1'b0 || pend_b !== 1'b0) begin errors++; $display("FAIL rst_pend got %0b%0b want 00", pend_a, pend_b); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alu_write();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234; rd_addr_a = 5'd5;
    #1;
    checks++; if (enable !== 1'b1 || addr_w !== 5'd5 || data_w !== 32'h1234) begin
      errors++; $display("FAIL alu_same_cycle got %0b/%0d/%h want 1/5/1234", enable, addr_w, data_w); end
`ifdef WB_BYPASS_EN
    checks++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== 32'h1234) begin
      errors++; $display("FAIL alu_fwd got %0b/%h want 1/1234", fwd_hit_a, fwd_data_a); end
`endif
    tick();
    alu_valid = 1'b0;
    #1;
    checks++; if (rf[5] !== 32'h1234) begin errors++; $display("FAIL alu_array got %h want 1234", rf[5]); end
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL alu_idle_en got %0b want 0", enable); end
  endtask

  task automatic test_mdu_write();
    rd_addr_a = 5'd7;
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'hAA;
    #1;
    checks++; if (mdu_ready !== 1'b1 || enable !== 1'b0 || pend_a !== 1'b0) begin
      errors++; $display("FAIL mdu_offer got rdy%0b en%0b pend%0b want 1 0 0", mdu_ready, enable, pend_a); end
    tick();
    mdu_valid = 1'b0;
    #1;
    checks++; if (enable !== 1'b1 || addr_w !== 5'd7 || data_w !== 32'hAA) begin
      errors++; $display("FAIL mdu_write got %0b/%0d/%h want 1/7/aa", enable, addr_w, data_w); end
    checks++; if (pend_a !== 1'b1) begin errors++; $display("FAIL mdu_pend_on got %0b want 1", pend_a); end
    tick();
    checks++; if (enable !== 1'b0 || pend_a !== 1'b0) begin
      errors++; $display("FAIL mdu_after got en%0b pend%0b want 0 0", enable, pend_a); end
    checks++; if (rf[7] !== 32'hAA) begin errors++; $display("FAIL mdu_array got %h want aa", rf[7]); end
  endtask

  task automatic test_fill_drain();
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11; rd_addr_b = 5'd13;
    for (int i = 0; i < 4; i++) begin
      mdu_valid = 1'b1; mdu_addr = 5'(10 + i); mdu_data = 32'hA0 + i;
      #1;
      checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %0b want 1", i, mdu_ready); end
      tick();
    end
    mdu_addr = 5'd14; mdu_data = 32'hA4;
    #1;
    checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", mdu_ready); end
    checks++; if (pend_b !== 1'b1) begin errors++; $display("FAIL full_pend_b got %0b want 1", pend_b); end
    checks++; if (enable !== 1'b1 || addr_w !== 5'd1) begin errors++; $display("FAIL full_alu got %0b/%0d want 1/1", enable, addr_w); end
    tick();
    alu_valid = 1'b0; mdu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (enable !== 1'b1 || addr_w !== 5'(10 + i) || data_w !== 32'hA0 + i) begin
        errors++; $display("FAIL drain[%0d] got %0b/%0d/%h want 1/%0d/%h", i, enable, addr_w, data_w, 10 + i, 32'hA0 + i); end
      checks++; if (mdu_ready !== (i != 0)) begin
        errors++; $display("FAIL drain_ready[%0d] got %0b want %0b", i, mdu_ready, i != 0); end
      tick();
    end
    checks++; if (enable !== 1'b0 || pend_b !== 1'b0 || mdu_ready !== 1'b1) begin
      errors++; $display("FAIL drained got en%0b pend%0b rdy%0b want 0 0 1", enable, pend_b, mdu_ready); end
    checks++; if (rf[13] !== 32'hA3 || rf[14] !== 32'h0) begin
      errors++; $display("FAIL drain_array got r13=%h r14=%h want a3/0", rf[13], rf[14]); end
  endtask

  task automatic test_kill();
    rd_addr_a = 5'd3;
    alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h22;
    mdu_valid = 1'b1; mdu_addr = 5'd3; mdu_data = 32'h1;
    tick();
    mdu_valid = 1'b0; alu_addr = 5'd3; alu_data = 32'h2;
    #1;
    checks++; if (enable !== 1'b1 || addr_w !== 5'd3 || data_w !== 32'h2) begin
      errors++; $display("FAIL kill_alu got %0b/%0d/%h want 1/3/2", enable, addr_w, data_w); end
    checks++; if (pend_a !== 1'b1) begin errors++; $display("FAIL kill_pend_before got %0b want 1", pend_a); end
    tick();
    alu_valid = 1'b0;
    #1;
    checks++; if (enable !== 1'b0 || pend_a !== 1'b0) begin
      errors++; $display("FAIL kill_dead got en%0b pend%0b want 0 0", enable, pend_a); end
    tick();
    checks++; if (rf[3] !== 32'h2 || enable !== 1'b0) begin
      errors++; $display("FAIL kill_final got r3=%h en%0b want 2/0", rf[3], enable); end
    // ALU and MDU to the same register in one cycle: the queued copy is born dead.
    rd_addr_a = 5'd4;
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h6;
    mdu_valid = 1'b1; mdu_addr = 5'd4; mdu_data = 32'h5;
    tick();
    alu_valid = 1'b0; mdu_valid = 1'b0;
    #1;
    checks++; if (enable !== 1'b0 || pend_a !== 1'b0) begin
      errors++; $display("FAIL kill_same got en%0b pend%0b want 0 0", enable, pend_a); end
    tick();
    checks++; if (rf[4] !== 32'h6) begin errors++; $display("FAIL kill_same_array got %h want 6", rf[4]); end
  endtask

  task automatic test_zero();
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h9;
    mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'h9;
    #1;
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL zero_alu got %0b want 0", enable); end
    tick();
    drive_idle();
    #1;
    checks++; if (enable !== 1'b0 || pend_a !== 1'b0 || pend_b !== 1'b0) begin
      errors++; $display("FAIL zero_mdu got en%0b pend%0b%0b want 0 00", enable, pend_a, pend_b); end
    tick();
    checks++; if (zero_writes !== 0) begin errors++; $display("FAIL zero_writes got %0d want 0", zero_writes); end
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h55; rd_addr_a = 5'd20;
    for (int i = 0; i < 3; i++) begin
      mdu_valid = 1'b1; mdu_addr = 5'(20 + i); mdu_data = 32'hC0 + i;
      tick();
    end
    mdu_valid = 1'b0;
    #1;
    checks++; if (pend_a !== 1'b1 || mdu_ready !== 1'b1) begin
      errors++; $display("FAIL mid_loaded got pend%0b rdy%0b want 1 1", pend_a, mdu_ready); end
    reset = 1'b1;
    #1;
    checks++; if (mdu_ready !== 1'b1 || enable !== 1'b0 || pend_a !== 1'b0) begin
      errors++; $display("FAIL mid_reset got rdy%0b en%0b pend%0b want 1 0 0", mdu_ready, enable, pend_a); end
    checks++; if (addr_w !== 5'd0 || data_w !== 32'd0) begin
      errors++; $display("FAIL mid_reset_port got %0d/%h want 0/0", addr_w, data_w); end
    tick();
    reset = 1'b0; alu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (enable !== 1'b0) begin errors++; $display("FAIL mid_release[%0d] got en%0b want 0", i, enable); end
      tick();
    end
    checks++; if (rf[20] !== 32'h0 || rf[21] !== 32'h0 || rf[22] !== 32'h0) begin
      errors++; $display("FAIL mid_array got %h %h %h want 0 0 0", rf[20], rf[21], rf[22]); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    zero_writes = 0;
    test_reset();
    test_alu_write();
    test_mdu_write();
    test_fill_drain();
    test_kill();
    test_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
